seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for the board's 8-digit common-anode seven-segment display. It owns the scan-rate prescaler and digit position counter, and holds a double-buffered 32-bit display value. It drives anode, segment and decimal-point lines directly. The CPU/debug path writes a new value at any time; the controller commits it only at a frame boundary, so a frame never shows digits from two different values.

## Interface
Parameters:
- `N`, 200_000 — scan divider; the digit position advances every `N/2` clock cycles. `N` must be even and ≥ 2.
- `DIGITS`, 8 — number of digits; fixed at 8 in this revision.

Ports:
- `clk` in 1 — system clock.
- `rst_n` in 1 — reset, synchronous, active-low.
- `wr_en` in 1 — single-cycle write strobe for the pending buffer.
- `wr_data` in 32 — eight hex nibbles; nibble `i` (bits `4i+3:4i`) is digit `i`, and digit 0 is rightmost.
- `wr_dp` in 8 — decimal-point enable per digit, active-high.
- `wr_mask` in 8 — digit enable per digit, active-high; 0 blanks the digit.
- `lz_en` in 1 — leading-zero suppression enable, level-sensitive, sampled every cycle.
- `an` out 8 — anode select, active-low, one-hot-low.
- `seg` out 7 — segments `{g,f,e,d,c,b,a}`, active-low.
- `dp` out 1 — decimal point, active-low.
- `pending` out 1 — high while a written value awaits commit.
- `frame_done` out 1 — one-cycle pulse when the position wraps from 7 to 0.

## Operation
- Prescaler `cnt` (32 bit) counts 0 to `N/2-1`. At the terminal count, `cnt` returns to 0 and `tick` asserts for one cycle; otherwise `cnt` increments.
- Position `pos` (3 bit) advances on `tick`, wrapping from 7 to 0. The wrap cycle is the frame boundary.
- Buffers: the pending set `{data, dp, mask}` and the active set with the same fields. `wr_en` loads the pending set and sets `pending`.
  - A second write before commit overwrites the pending set; last write wins.
- Commit: on the frame-boundary tick with `pending`=1, pending is copied to active and `pending` clears.
  - If `wr_en` coincides with a commit tick, the new write data is committed directly and `pending` stays 0.
- Digit value: `d = active.data[4*pos+3 : 4*pos]`, decoded hex 0–F to segments with the standard patterns.
  - Example: 0 → `seg`=7'b1000000; 8 → 7'b0000000.
- Blanking: digit `pos` is blanked (`seg`=7'h7F, `dp`=1) if either condition holds:
  - `active.mask[pos]`=0; or
  - `lz_en`=1, `pos`≠0, and nibbles `pos..7` are all zero.
  - Digit 0 is never suppressed by leading-zero logic; the mask can still blank it.
- `an` = ~(1<<pos) always, even for blanked digits. Brightness uniformity is preserved by the constant duty cycle.
- `dp` = ~active.dp[pos] unless the digit is blanked.

## Timing
- Reset (`rst_n`=0 at a `clk` edge) sets:
  - `cnt`=0, `pos`=0, both buffers all-zero, `pending`=0;
  - `an`=8'hFF, `seg`=7'h7F, `dp`=1, `frame_done`=0.
- Reset mid-frame aborts the scan; any pending write is lost.
- All outputs are registered. `an`/`seg`/`dp` reflect the new `pos` one cycle after the `tick` cycle.
- On the first clock edge after reset release, outputs show digit 0 of the all-zero active buffer, which is blanked because the mask is 0.
- `frame_done` asserts in the same cycle that `pos` becomes 0, registered alongside `an`. The commit takes effect in that same cycle, so digit 0 of the new frame shows the new value.
- Write-to-visible latency: at most one full frame (8·`N/2` cycles) plus 1 cycle.
- `pending` rises the cycle after `wr_en` and falls the cycle after the committing tick.

## Structure
- Package `seg_pkg`: `DIGITS` constant, the 16-entry hex-to-segment constant table, `SEG_BLANK`=7'h7F, and a typedef for the `{data, dp, mask}` buffer struct.
- Sub-module `seg_hex_decode`: combinational, 4-bit in to 7-bit active-low out.
- Prescaler, position counter, buffers and output registers all live in `seg_scan_ctrl`.

## Test plan
Use `N`=4 (tick every 2 cycles) unless noted.
- Reset, then no write → `an` cycles FE, FD, FB, … 7F, FE every 2 cycles; `seg`=7F throughout; `frame_done` pulses every 16 cycles.
- Write `wr_data`=32'h0123_4567, `wr_mask`=FF, `wr_dp`=01, `lz_en`=0 mid-frame → `pending`=1 until the next wrap. Then:
  - digit 0 shows 7 (7'b1111000) with `dp`=0;
  - digit 7 shows 0 (7'b1000000).
- Write 32'h0000_00A0 with `lz_en`=1 → digits 7–2 blank, digit 1 shows A (7'b0001000), digit 0 shows 0. Write 0 → only digit 0 shows 0.
- Two writes (32'h1111_1111, then 32'h2222_2222) within one frame → only 2s are ever displayed; 1s never appear on `seg`.
- `wr_en` on the exact wrap cycle → the value is visible on digit 0 in the same frame; `pending` never rises.
- Assert `rst_n`=0 for 1 cycle mid-frame with `pending`=1 → next cycle `an`=FF, `pending`=0; the scan restarts at digit 0 with blanked output.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Segment encodings are active-low in {g,f,e,d,c,b,a} order.
package seg_pkg;

  localparam int DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  mask;
  } disp_buf_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Hex nibble to active-low seven-segment pattern; purely combinational.
// No handshake: output follows input in the same cycle.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed display scanner with frame-boundary commit of a double-buffered value.
// All outputs registered, one cycle behind the scan state change; writes are never refused.
module seg_scan_ctrl #(
  parameter int N      = 200_000,
  parameter int DIGITS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [31:0]       wr_data,
  input  logic [7:0]        wr_dp,
  input  logic [7:0]        wr_mask,
  input  logic              lz_en,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic              pending,
  output logic              frame_done
);
  import seg_pkg::*;

  localparam logic [31:0] TERM = 32'(N / 2 - 1);

  logic [31:0] cnt;
  logic [2:0]  pos;
  logic [2:0]  pos_nxt;
  logic        tick;
  logic        wrap;
  disp_buf_t   pend_buf;
  disp_buf_t   act_buf;
  disp_buf_t   act_nxt;
  logic [3:0]  nib;
  logic [6:0]  dec_seg;
  logic        upper_zero;
  logic        blank;

  // Outputs are built from next-cycle scan state so a commit shows on digit 0
  // in the very cycle frame_done pulses.
  always_comb begin
    tick    = (cnt == TERM);
    wrap    = tick && (pos == 3'd7);
    pos_nxt = tick ? pos + 3'd1 : pos;
    act_nxt = act_buf;
    if (wrap) begin
      if (wr_en) begin
        act_nxt = '{data: wr_data, dp: wr_dp, mask: wr_mask};
      end else if (pending) begin
        act_nxt = pend_buf;
      end
    end
  end

  always_comb begin
    nib        = act_nxt.data[{pos_nxt, 2'b00} +: 4];
    upper_zero = ((act_nxt.data >> {pos_nxt, 2'b00}) == 32'd0);
    blank      = !act_nxt.mask[pos_nxt] || (lz_en && (pos_nxt != 3'd0) && upper_zero);
  end

  seg_hex_decode u_dec (
    .hex (nib),
    .seg (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      pos        <= '0;
      pend_buf   <= '0;
      act_buf    <= '0;
      pending    <= 1'b0;
      an         <= '1;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + 32'd1;
      pos        <= pos_nxt;
      act_buf    <= act_nxt;
      frame_done <= wrap;
      if (wr_en) begin
        pend_buf <= '{data: wr_data, dp: wr_dp, mask: wr_mask};
      end
      if (wrap) begin
        pending <= 1'b0;
      end else if (wr_en) begin
        pending <= 1'b1;
      end
      an  <= ~(DIGITS'(1) << pos_nxt);
      seg <= blank ? SEG_BLANK : dec_seg;
      dp  <= blank | ~act_nxt.dp[pos_nxt];
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with N=4: per-digit expectations are queued
// when a value is written and popped as the scan reaches each digit.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic [7:0]  wr_dp = '0;
  logic [7:0]  wr_mask = '0;
  logic        lz_en = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        pending;
  logic        frame_done;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t exp_q[$];

  seg_scan_ctrl #(.N(4), .DIGITS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .wr_mask    (wr_mask),
    .lz_en      (lz_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .pending    (pending),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [6:0] hex_pat(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic expect_frame(input logic [31:0] data, input logic [7:0] dpm,
                              input logic [7:0] mask, input bit lz);
    for (int d = 0; d < 8; d++) begin
      exp_t e;
      logic [31:0] upper;
      bit bl;
      upper = data >> (4 * d);
      bl = !mask[d] || (lz && d != 0 && upper == 32'd0);
      e.an = 8'hFF;
      e.an[d] = 1'b0;
      e.seg = bl ? 7'h7F : hex_pat(data[4*d +: 4]);
      e.dp = bl ? 1'b1 : !dpm[d];
      exp_q.push_back(e);
    end
  endtask

  // Call while sampling the frame_done cycle; returns at the next frame_done cycle.
  task automatic scan_frame(input string tag);
    exp_t e;
    e = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1};
    for (int k = 0; k < 16; k++) begin
      if (k % 2 == 0) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL %s_queue k=%0d: scoreboard empty, required an entry", tag, k);
          return;
        end
        e = exp_q.pop_front();
      end
      vectors++;
      if (an !== e.an || seg !== e.seg || dp !== e.dp || frame_done !== (k == 0)) begin
        miscompares++;
        $display("FAIL %s k=%0d: an=%h seg=%h dp=%b fd=%b, required an=%h seg=%h dp=%b fd=%b",
                 tag, k, an, seg, dp, frame_done, e.an, e.seg, e.dp, (k == 0));
      end
      step();
    end
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (!frame_done && n < 64);
    vectors++;
    if (!frame_done) begin
      miscompares++;
      $display("FAIL %s_wait: frame_done=%b after %0d cycles, required 1", tag, frame_done, n);
    end
  endtask

  task automatic do_write(input logic [31:0] data, input logic [7:0] dpm, input logic [7:0] mask);
    wr_en = 1'b1;
    wr_data = data;
    wr_dp = dpm;
    wr_mask = mask;
    step();
    wr_en = 1'b0;
  endtask

  task automatic check_pending(input string tag, input logic req);
    vectors++;
    if (pending !== req) begin
      miscompares++;
      $display("FAIL %s: pending=%b, required %b", tag, pending, req);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    vectors++;
    if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || pending !== 1'b0 || frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: an=%h seg=%h dp=%b pend=%b fd=%b, required FF 7F 1 0 0",
               an, seg, dp, pending, frame_done);
    end
    rst_n = 1'b1;
    step();
    vectors++;
    if (an !== 8'hFE || seg !== 7'h7F || dp !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: an=%h seg=%h dp=%b, required FE 7F 1", an, seg, dp);
    end
  endtask

  task automatic test_idle_scan();
    wait_frame("idle");
    expect_frame(32'h0, 8'h00, 8'h00, 1'b0);
    expect_frame(32'h0, 8'h00, 8'h00, 1'b0);
    scan_frame("idle_f0");
    scan_frame("idle_f1");
  endtask

  task automatic test_write();
    int n = 0;
    repeat (5) step();
    do_write(32'h0123_4567, 8'h01, 8'hFF);
    check_pending("write_pending_rise", 1'b1);
    while (!frame_done && n < 64) begin
      check_pending("write_pending_hold", 1'b1);
      step();
      n++;
    end
    vectors++;
    if (!frame_done) begin
      miscompares++;
      $display("FAIL write_wait: frame_done=%b, required 1", frame_done);
    end
    check_pending("write_pending_fall", 1'b0);
    expect_frame(32'h0123_4567, 8'h01, 8'hFF, 1'b0);
    scan_frame("write");
  endtask

  task automatic test_lz();
    lz_en = 1'b1;
    do_write(32'h0000_00A0, 8'h00, 8'hFF);
    wait_frame("lz_a0");
    expect_frame(32'h0000_00A0, 8'h00, 8'hFF, 1'b1);
    scan_frame("lz_a0");
    do_write(32'h0, 8'h00, 8'hFF);
    wait_frame("lz_zero");
    expect_frame(32'h0, 8'h00, 8'hFF, 1'b1);
    scan_frame("lz_zero");
    lz_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n = 0;
    step();
    do_write(32'h1111_1111, 8'h00, 8'hFF);
    step();
    step();
    do_write(32'h2222_2222, 8'h00, 8'hEF);
    while (!frame_done && n < 64) begin
      vectors++;
      if (seg === 7'b1111001) begin
        miscompares++;
        $display("FAIL b2b_no_ones: seg=%h, required anything but 79", seg);
      end
      step();
      n++;
    end
    check_pending("b2b_pending_fall", 1'b0);
    expect_frame(32'h2222_2222, 8'h00, 8'hEF, 1'b0);
    expect_frame(32'h2222_2222, 8'h00, 8'hEF, 1'b0);
    scan_frame("b2b_f0");
    scan_frame("b2b_f1");
  endtask

  task automatic test_wrap_write();
    repeat (15) step();
    do_write(32'h89AB_CDEF, 8'h80, 8'hFF);
    check_pending("wrap_no_pending", 1'b0);
    expect_frame(32'h89AB_CDEF, 8'h80, 8'hFF, 1'b0);
    scan_frame("wrap");
    check_pending("wrap_still_no_pending", 1'b0);
  endtask

  task automatic test_reset_mid();
    repeat (4) step();
    do_write(32'h1234_5678, 8'hFF, 8'hFF);
    check_pending("rmid_pending", 1'b1);
    rst_n = 1'b0;
    step();
    vectors++;
    if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || pending !== 1'b0 || frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_reset: an=%h seg=%h dp=%b pend=%b fd=%b, required FF 7F 1 0 0",
               an, seg, dp, pending, frame_done);
    end
    rst_n = 1'b1;
    step();
    vectors++;
    if (an !== 8'hFE || seg !== 7'h7F || dp !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_restart: an=%h seg=%h dp=%b, required FE 7F 1", an, seg, dp);
    end
    wait_frame("rmid");
    expect_frame(32'h0, 8'h00, 8'h00, 1'b0);
    scan_frame("rmid_blank");
    check_pending("rmid_lost", 1'b0);
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_write();
    test_lz();
    test_back_to_back();
    test_wrap_write();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
